// File: rtl/twisted_ring_ctr.sv
// rtl/twisted_ring_ctr.sv - Johnson / one-hot ring counter with self-correction
//
// Purpose: WIDTH-bit shift counter. It runs either as a twisted ring (Johnson,
// 2*WIDTH states) or as a one-hot ring (WIDTH states) and can step in either
// direction. When enabled from an illegal state it returns to the home state.
//
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   synchronous active-high reset, loads the current Mode's home state
//   En       in   step enable
//   Mode     in   0 = Johnson, 1 = one-hot ring
//   Dir      in   0 = shift toward MSB, 1 = shift toward LSB
//   Load     in   synchronous parallel load of LoadVal, written unchanged
//   LoadVal  in   parallel load value
//   Q        out  registered counter state
//   Phase    out  combinational index of Q in the current sequence (0 if illegal)
//   Illegal  out  combinational, Q is not a state of the current sequence
//   Wrap     out  registered one-cycle pulse after a step that wraps the sequence
module twisted_ring_ctr #(
   parameter  int WIDTH = 5,
   localparam int PW    = $clog2(2*WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Mode,
   input  logic             Dir,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   output logic [WIDTH-1:0] Q,
   output logic [PW-1:0]    Phase,
   output logic             Illegal,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
   localparam logic [PW:0]      J_SPAN = (PW+1)'(2*WIDTH);
   localparam logic [PW:0]      J_LAST = (PW+1)'(2*WIDTH-1);
   localparam logic [PW:0]      R_LAST = (PW+1)'(WIDTH-1);

   logic [WIDTH-1:0] q_inv;
   logic [PW:0]      ones;
   logic [PW:0]      ring_idx;
   logic             j_legal;
   logic             r_legal;
   logic [PW:0]      phase_w;
   logic [WIDTH-1:0] home;
   logic [WIDTH-1:0] step_val;
   logic             at_wrap;

   assign q_inv = ~Q;

   // Popcount, and the position of the set bit (meaningful only when one-hot).
   always_comb begin
      ones     = '0;
      ring_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + {{PW{1'b0}}, Q[i]};
         if (Q[i]) ring_idx = (PW+1)'(i);
      end
   end

   // Johnson legal: zero, a run of ones from bit 0 (x & (x+1) == 0), or a run of
   // ones from the MSB (the complement is a run from bit 0).
   assign j_legal = (Q == '0)
                  | (Q[0]       & ((Q & (Q + ONE)) == '0))
                  | (Q[WIDTH-1] & ((q_inv & (q_inv + ONE)) == '0));
   assign r_legal = (Q != '0) & ((Q & (Q - ONE)) == '0);

   assign Illegal = Mode ? ~r_legal : ~j_legal;

   // Johnson fill phase counts the ones; the drain phase counts down from 2*WIDTH.
   always_comb begin
      phase_w = '0;
      if (Illegal)
         phase_w = '0;
      else if (Mode)
         phase_w = ring_idx;
      else if (Q[0] || (Q == '0))
         phase_w = ones;
      else
         phase_w = J_SPAN - ones;
   end

   assign Phase = phase_w[PW-1:0];

   assign home = Mode ? ONE : '0;

   always_comb begin
      step_val = Q;
      case ({Mode, Dir})
         2'b00:   step_val = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
         2'b01:   step_val = {~Q[0], Q[WIDTH-1:1]};
         2'b10:   step_val = {Q[WIDTH-2:0], Q[WIDTH-1]};
         default: step_val = {Q[0], Q[WIDTH-1:1]};
      endcase
   end

   assign at_wrap = Dir ? (phase_w == '0) : (phase_w == (Mode ? R_LAST : J_LAST));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Q    <= home;
         Wrap <= 1'b0;
      end else if (Load) begin
         Q    <= LoadVal;
         Wrap <= 1'b0;
      end else if (En && Illegal) begin
         Q    <= home;
         Wrap <= 1'b0;
      end else if (En) begin
         Q    <= step_val;
         Wrap <= at_wrap;
      end else begin
         Wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_twisted_ring_ctr.sv
// tb/tb_twisted_ring_ctr.sv - self-checking bench for twisted_ring_ctr
module tb_twisted_ring_ctr;

   localparam int W  = 5;
   localparam int PW = $clog2(2*W);

   logic          clk;
   logic          reset;
   logic          en;
   logic          mode;
   logic          dir;
   logic          load;
   logic [W-1:0]  loadval;
   logic [W-1:0]  q;
   logic [PW-1:0] phase;
   logic          illegal;
   logic          wrap;

   int n_chk = 0;
   int n_err = 0;

   logic [W-1:0] mq;
   logic         mwrap;

   twisted_ring_ctr #(.WIDTH(W)) dut (
      .Clk(clk), .Reset(reset), .En(en), .Mode(mode), .Dir(dir), .Load(load),
      .LoadVal(loadval), .Q(q), .Phase(phase), .Illegal(illegal), .Wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int seq_len(input logic m);
      return m ? W : 2*W;
   endfunction

   // k-th state of the sequence, built from its shape: fill from bit 0, then drain.
   function automatic logic [W-1:0] seq_val(input logic m, input int k);
      int v;
      if (m)
         v = 1 << k;
      else if (k <= W)
         v = (1 << k) - 1;
      else
         v = ((1 << W) - 1) ^ ((1 << (k - W)) - 1);
      return W'(v);
   endfunction

   function automatic int idx_of(input logic [W-1:0] v, input logic m);
      for (int k = 0; k < seq_len(m); k++)
         if (seq_val(m, k) == v) return k;
      return -1;
   endfunction

   task automatic model_edge();
      int k;
      int nk;
      int n;
      if (reset) begin
         mq = mode ? W'(1) : '0;
         mwrap = 1'b0;
      end else if (load) begin
         mq = loadval;
         mwrap = 1'b0;
      end else if (en) begin
         k = idx_of(mq, mode);
         n = seq_len(mode);
         if (k < 0) begin
            mq = mode ? W'(1) : '0;
            mwrap = 1'b0;
         end else begin
            nk = dir ? k - 1 : k + 1;
            mwrap = (nk < 0) || (nk >= n);
            mq = seq_val(mode, (nk + n) % n);
         end
      end else begin
         mwrap = 1'b0;
      end
   endtask

   task automatic cyc(input logic r, input logic ld, input logic e, input logic m,
                      input logic d, input logic [W-1:0] lv);
      int k;
      reset = r; load = ld; en = e; mode = m; dir = d; loadval = lv;
      model_edge();
      @(posedge clk);
      #1;
      k = idx_of(mq, mode);
      chk("q", q, mq);
      chk("wrap", wrap, mwrap);
      chk("illegal", illegal, k < 0);
      chk("phase", phase, (k < 0) ? 0 : k);
   endtask

   logic [W-1:0] jtab [0:10];
   logic [W-1:0] rtab [0:5];

   initial begin
      logic m;
      logic d;
      jtab = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
               5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
      rtab = '{5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
      reset = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; loadval = '0;
      mq = '0; mwrap = 1'b0;
      @(posedge clk);
      #1;

      // Johnson up walk from reset
      cyc(1, 0, 0, 0, 0, '0);
      chk("rst_q", q, 0);
      chk("rst_wrap", wrap, 0);
      for (int i = 1; i <= 10; i++) begin
         cyc(0, 0, 1, 0, 0, '0);
         chk("j_walk_q", q, jtab[i]);
         chk("j_walk_phase", phase, i % 10);
         chk("j_walk_wrap", wrap, i == 10);
      end
      cyc(0, 0, 0, 0, 0, '0);
      chk("j_hold_wrap", wrap, 0);

      // ring down walk
      cyc(1, 0, 0, 1, 1, '0);
      chk("r_rst_q", q, 1);
      for (int i = 1; i <= 5; i++) begin
         cyc(0, 0, 1, 1, 1, '0);
         chk("r_walk_q", q, rtab[i]);
         chk("r_walk_wrap", wrap, i == 1);
      end

      // load illegal, then self-correct
      cyc(0, 1, 0, 0, 0, 5'b10101);
      chk("ld_q", q, 5'b10101);
      chk("ld_illegal", illegal, 1);
      chk("ld_phase", phase, 0);
      cyc(0, 0, 1, 0, 0, '0);
      chk("fix_q", q, 0);
      chk("fix_wrap", wrap, 0);

      // load beats enable
      cyc(0, 1, 0, 0, 0, 5'b00111);
      cyc(0, 1, 1, 0, 0, 5'b11000);
      chk("ld_win_q", q, 5'b11000);
      chk("ld_win_phase", phase, 8);

      // direction reversal, then reset beats enable
      cyc(0, 1, 0, 0, 0, 5'b01111);
      cyc(0, 0, 1, 0, 1, '0);
      chk("rev_q", q, 5'b00111);
      cyc(1, 0, 1, 0, 1, '0);
      chk("rst_en_q", q, 0);

      // mode switch onto an illegal state
      cyc(0, 1, 0, 0, 0, 5'b00011);
      mode = 1'b1;
      #1;
      chk("msw_illegal", illegal, 1);
      cyc(0, 0, 1, 1, 0, '0);
      chk("msw_q", q, 1);

      // randomized run against the sequence model
      m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) m = ~m;
         d = 1'($urandom_range(0, 1));
         cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 75), m, d, W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
